// File: rtl/ai_host_sequencer_if.sv
// Register bus between ai_host_sequencer (master) and the AI targeting engine's 64-bit slave.
// Standard wait-request handshake: a transfer completes on a cycle with strobe=1 and waitrequest=0.
interface ai_host_sequencer_if;
    logic [2:0]  av_addr;
    logic        av_write;
    logic        av_read;
    logic [63:0] av_writedata;
    logic        av_waitrequest;
    logic [63:0] av_readdata;

    modport master (
        output av_addr, av_write, av_read, av_writedata,
        input  av_waitrequest, av_readdata
    );

    modport slave (
        input  av_addr, av_write, av_read, av_writedata,
        output av_waitrequest, av_readdata
    );
endinterface

// File: rtl/ai_host_sequencer.sv
// Bus-master sequencer: writes board words, ship mask and start word, then reads the target index.
// Optional per-transfer stall timeout is compiled in with `define AI_TIMEOUT_EN.
module ai_host_sequencer #(
`ifdef AI_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 1024,
`endif
    parameter int NUM_WORDS = 4,
    parameter int SHIP_W    = 5,
    parameter int IDX_W     = 7
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req,
    input  logic [64*NUM_WORDS-1:0]   board,
    input  logic [SHIP_W-1:0]         ships,
    output logic                      busy,
    output logic                      done,
    output logic [IDX_W-1:0]          result,
    output logic                      err,
    ai_host_sequencer_if.master       bus
);
    localparam int              CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);
    localparam logic [2:0]      SHIP_ADDR = 3'(NUM_WORDS + 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_BOARD,
        WR_SHIPS,
        WR_START,
        RD_RES
    } state_t;

    state_t                  state, state_n;
    logic [CNT_W-1:0]        word_cnt, word_cnt_n;
    logic                    write_q, write_n;
    logic                    read_q, read_n;
    logic [2:0]              addr_q, addr_n;
    logic [63:0]             wdata_q, wdata_n;
    logic                    busy_n, done_n;
    logic [IDX_W-1:0]        result_n;
    logic                    accept;
    logic                    xfer_done;
    logic [64*NUM_WORDS-1:0] board_q;
    logic [SHIP_W-1:0]       ships_q;
    logic                    unused_readdata;

    assign xfer_done       = (write_q | read_q) & ~bus.av_waitrequest;
    assign unused_readdata = ^bus.av_readdata[63:IDX_W];

    assign bus.av_write     = write_q;
    assign bus.av_read      = read_q;
    assign bus.av_addr      = addr_q;
    assign bus.av_writedata = wdata_q;

`ifdef AI_TIMEOUT_EN
    localparam int              STALL_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);

    logic [STALL_W-1:0] stall_cnt, stall_n;
    logic               err_q, err_n;

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no path can leave it
    // unassigned and infer a latch; blocking '=' is correct inside combinational logic.
    always_comb begin
        state_n    = state;
        word_cnt_n = word_cnt;
        write_n    = write_q;
        read_n     = read_q;
        addr_n     = addr_q;
        wdata_n    = wdata_q;
        busy_n     = busy;
        done_n     = 1'b0;
        result_n   = result;
        accept     = 1'b0;
`ifdef AI_TIMEOUT_EN
        err_n      = err_q;
        stall_n    = '0;
`endif

        case (state)
            IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    state_n    = WR_BOARD;
                    busy_n     = 1'b1;
                    word_cnt_n = '0;
                end
            end
            WR_BOARD: begin
                // First cycle after acceptance raises the strobe for word 0.
                if (!write_q) begin
                    write_n = 1'b1;
                    addr_n  = 3'(word_cnt) + 3'd1;
                    wdata_n = board_q[64*int'(word_cnt) +: 64];
                end else if (xfer_done) begin
                    if (word_cnt == LAST_WORD) begin
                        state_n    = WR_SHIPS;
                        word_cnt_n = '0;
                        addr_n     = SHIP_ADDR;
                        wdata_n    = 64'(ships_q);
                    end else begin
                        word_cnt_n = word_cnt + 1'b1;
                        addr_n     = 3'(word_cnt_n) + 3'd1;
                        wdata_n    = board_q[64*int'(word_cnt_n) +: 64];
                    end
                end
            end
            WR_SHIPS: begin
                if (xfer_done) begin
                    state_n = WR_START;
                    addr_n  = 3'd0;
                    wdata_n = 64'd1;
                end
            end
            WR_START: begin
                if (xfer_done) begin
                    state_n = RD_RES;
                    write_n = 1'b0;
                    read_n  = 1'b1;
                    addr_n  = 3'd0;
                    wdata_n = '0;
                end
            end
            RD_RES: begin
                if (xfer_done) begin
                    state_n  = IDLE;
                    read_n   = 1'b0;
                    result_n = bus.av_readdata[IDX_W-1:0];
                    done_n   = 1'b1;
                    busy_n   = 1'b0;
`ifdef AI_TIMEOUT_EN
                    err_n    = 1'b0;
`endif
                end
            end
            default: begin
                state_n = IDLE;
                write_n = 1'b0;
                read_n  = 1'b0;
                busy_n  = 1'b0;
            end
        endcase

`ifdef AI_TIMEOUT_EN
        // Consecutive stall cycles of the current transfer; abort overrides the FSM.
        if ((write_q | read_q) && bus.av_waitrequest) begin
            if (stall_cnt == STALL_LAST) begin
                state_n    = IDLE;
                word_cnt_n = '0;
                write_n    = 1'b0;
                read_n     = 1'b0;
                addr_n     = 3'd0;
                wdata_n    = '0;
                busy_n     = 1'b0;
                done_n     = 1'b1;
                err_n      = 1'b1;
                result_n   = '1;
            end else begin
                stall_n = stall_cnt + 1'b1;
            end
        end
`endif
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            word_cnt <= '0;
            write_q  <= 1'b0;
            read_q   <= 1'b0;
            addr_q   <= 3'd0;
            wdata_q  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
`ifdef AI_TIMEOUT_EN
            err_q     <= 1'b0;
            stall_cnt <= '0;
`endif
        end else begin
            state    <= state_n;
            word_cnt <= word_cnt_n;
            write_q  <= write_n;
            read_q   <= read_n;
            addr_q   <= addr_n;
            wdata_q  <= wdata_n;
            busy     <= busy_n;
            done     <= done_n;
            result   <= result_n;
`ifdef AI_TIMEOUT_EN
            err_q     <= err_n;
            stall_cnt <= stall_n;
`endif
        end
    end

    // NOTE: the query snapshot is plain data storage, only read after a load, so it
    // carries no reset and maps onto cheap non-reset flops.
    always_ff @(posedge clock) begin
        if (accept) begin
            board_q <= board;
            ships_q <= ships;
        end
    end
endmodule

// File: tb/tb_ai_host_sequencer.sv
// Self-checking bench for ai_host_sequencer: stalling slave model, transaction scoreboard,
// directed and randomized queries; the timeout case is exercised when AI_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_ai_host_sequencer;
    localparam int NUM_WORDS = 4;
    localparam int SHIP_W    = 5;
    localparam int IDX_W     = 7;
`ifdef AI_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 16;
`endif

    typedef struct {
        bit          wr;
        logic [2:0]  addr;
        logic [63:0] data;
    } xfer_t;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic                    req   = 1'b0;
    logic [64*NUM_WORDS-1:0] board = '0;
    logic [SHIP_W-1:0]       ships = '0;
    logic                    busy, done, err;
    logic [IDX_W-1:0]        result;

    ai_host_sequencer_if bus();

    ai_host_sequencer #(
`ifdef AI_TIMEOUT_EN
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
`endif
        .NUM_WORDS(NUM_WORDS),
        .SHIP_W(SHIP_W),
        .IDX_W(IDX_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .board (board),
        .ships (ships),
        .busy  (busy),
        .done  (done),
        .result(result),
        .err   (err),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int          tests = 0;
    int          fails = 0;
    int          stall_w = 0;
    int          stall_r = 0;
    logic [63:0] slave_rd = '0;
    xfer_t       seen_q[$];
    xfer_t       exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [64*NUM_WORDS-1:0] rand_board();
        logic [64*NUM_WORDS-1:0] v;
        for (int i = 0; i < 2*NUM_WORDS; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Slave: stalls each transfer for stall_w/stall_r cycles, checks the master holds
    // the transfer steady while stalled, and logs every completed transfer.
    initial begin : slave
        bit          active;
        int          left;
        logic        s_wr, s_rd;
        logic [2:0]  s_addr;
        logic [63:0] s_data;
        active = 0;
        left   = 0;
        bus.av_waitrequest = 1'b0;
        bus.av_readdata    = '0;
        forever begin
            @(negedge clock);
            if (reset || !(bus.av_write || bus.av_read)) begin
                active = 0;
                bus.av_waitrequest = 1'b0;
                bus.av_readdata    = {$urandom, $urandom};
            end else begin
                check("no_dual_strobe", bus.av_write & bus.av_read, 1'b0);
                if (!active) begin
                    active = 1;
                    left   = bus.av_read ? stall_r : stall_w;
                    s_wr   = bus.av_write;
                    s_rd   = bus.av_read;
                    s_addr = bus.av_addr;
                    s_data = bus.av_writedata;
                end else begin
                    check("hold_write", bus.av_write, s_wr);
                    check("hold_read",  bus.av_read,  s_rd);
                    check("hold_addr",  bus.av_addr,  s_addr);
                    if (s_wr) check("hold_data", bus.av_writedata, s_data);
                end
                if (left > 0) begin
                    left--;
                    bus.av_waitrequest = 1'b1;
                    bus.av_readdata    = {$urandom, $urandom};
                end else begin
                    active = 0;
                    bus.av_waitrequest = 1'b0;
                    if (s_rd) begin
                        bus.av_readdata = slave_rd;
                        seen_q.push_back('{1'b0, s_addr, slave_rd});
                    end else begin
                        seen_q.push_back('{1'b1, s_addr, s_data});
                    end
                end
            end
        end
    end

    // One query: reference sequence is four board writes, ship mask, start word, one read.
    // Latency counts negedges after the acceptance edge: the first strobe appears one
    // cycle after acceptance, each transfer lasts stall+1 cycles, done follows the read.
    task automatic run_query(
        input logic [64*NUM_WORDS-1:0] b,
        input logic [SHIP_W-1:0]       s,
        input logic [63:0]             rd,
        input int                      sw,
        input int                      sr,
        input bit                      prelaunched,
        input bit                      pulse,
        input bit                      chain,
        input logic [64*NUM_WORDS-1:0] nb,
        input logic [SHIP_W-1:0]       ns,
        input bit                      expect_timeout
    );
        int n, read_start, exp_n, tmo;
        bit seen_done;
`ifdef AI_TIMEOUT_EN
        tmo = TIMEOUT_CYCLES;
`else
        tmo = 0;
`endif
        stall_w  = sw;
        stall_r  = sr;
        slave_rd = rd;
        seen_q.delete();
        exp_q.delete();
        for (int i = 0; i < NUM_WORDS; i++) exp_q.push_back('{1'b1, 3'(i + 1), b[64*i +: 64]});
        exp_q.push_back('{1'b1, 3'(NUM_WORDS + 1), 64'(s)});
        exp_q.push_back('{1'b1, 3'd0, 64'd1});
        if (!expect_timeout) exp_q.push_back('{1'b0, 3'd0, rd});

        read_start = 2 + (NUM_WORDS + 2) * (sw + 1);
        exp_n      = expect_timeout ? read_start + tmo : read_start + sr + 1;

        if (!prelaunched) begin
            @(negedge clock);
            board = b;
            ships = s;
            req   = 1'b1;
        end
        @(posedge clock);
        @(negedge clock);
        n   = 1;
        req = 1'b0;
        check("busy_after_accept", busy, 1'b1);
        board = rand_board();
        ships = ~s;

        seen_done = 0;
        while (!seen_done && n < 400) begin
            req = 1'b0;
            if (done) begin
                seen_done = 1;
            end else begin
                if (pulse && (n == 3 || n == read_start)) req = 1'b1;
                @(negedge clock);
                n++;
            end
        end
        check("done_seen", seen_done, 1'b1);
        check("done_latency", n, exp_n);
        check("result", result, expect_timeout ? {IDX_W{1'b1}} : rd[IDX_W-1:0]);
        check("err", err, expect_timeout);
        check("busy_at_done", busy, 1'b0);
        check("strobes_at_done", {bus.av_write, bus.av_read}, 2'b00);
        check("xfer_count", seen_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
            check("xfer_wr",   seen_q[i].wr,   exp_q[i].wr);
            check("xfer_addr", seen_q[i].addr, exp_q[i].addr);
            check("xfer_data", seen_q[i].data, exp_q[i].data);
        end

        if (chain) begin
            board = nb;
            ships = ns;
            req   = 1'b1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clock);
                check("idle_done", done, 1'b0);
                check("idle_busy", busy, 1'b0);
                check("idle_strobes", {bus.av_write, bus.av_read}, 2'b00);
            end
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [64*NUM_WORDS-1:0] nb;
        logic [SHIP_W-1:0]       ns;
        int                      n;

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_busy",   busy,   1'b0);
        check("rst_done",   done,   1'b0);
        check("rst_result", result, '0);
        check("rst_err",    err,    1'b0);
        check("rst_write",  bus.av_write, 1'b0);
        check("rst_read",   bus.av_read,  1'b0);
        check("rst_addr",   bus.av_addr,  3'd0);
        check("rst_wdata",  bus.av_writedata, 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Zero-wait slave, empty board, all ships live
        run_query('0, 5'b11111, 64'd42, 0, 0, 0, 0, 0, '0, '0, 0);

        // Three stall cycles on every transfer
        run_query(rand_board(), 5'($urandom), {$urandom, $urandom}, 3, 3, 0, 0, 0, '0, '0, 0);

        // req re-pulsed in WR_BOARD and RD_RES, then req together with done
        nb = rand_board();
        ns = 5'($urandom);
        run_query(rand_board(), 5'($urandom), 64'd77, 0, 0, 0, 1, 1, nb, ns, 0);
        run_query(nb, ns, 64'd13, 0, 0, 1, 0, 0, '0, '0, 0);

        // Word 2 marker, partial ship mask, upper readdata bits ignored
        run_query(256'(64'hDEAD_BEEF) << 128, 5'b00101, 64'hFFFF_FFFF_FFFF_FF63, 0, 0, 0, 0, 0, '0, '0, 0);
        check("addr3_payload", seen_q[2].data, 64'hDEAD_BEEF);
        check("addr5_payload", seen_q[4].data, 64'h05);
        check("result_63", result, 7'h63);

        // Randomized queries
        for (int t = 0; t < 5; t++)
            run_query(rand_board(), 5'($urandom), {$urandom, $urandom},
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 4)), 0, 0, 0, '0, '0, 0);

        // Reset while stalled in WR_SHIPS
        stall_w = 4;
        stall_r = 0;
        @(negedge clock);
        board = rand_board();
        ships = 5'h1b;
        req   = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req = 1'b0;
        n = 0;
        while (!(bus.av_write && bus.av_addr == 3'd5) && n < 200) begin
            @(negedge clock);
            n++;
        end
        #1;
        check("reached_wr_ships", bus.av_write && bus.av_addr == 3'd5, 1'b1);
        check("stalled_wr_ships", bus.av_waitrequest, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_mid_write", bus.av_write, 1'b0);
        check("rst_mid_busy",  busy, 1'b0);
        check("rst_mid_addr",  bus.av_addr, 3'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("post_rst_quiet", {bus.av_write, bus.av_read, busy, done}, 4'b0000);
        end

        // Recovery after reset
        run_query(rand_board(), 5'($urandom), {$urandom, $urandom}, 1, 2, 0, 0, 0, '0, '0, 0);

`ifdef AI_TIMEOUT_EN
        // Read stalls forever: abort after TIMEOUT_CYCLES stall cycles
        run_query(rand_board(), 5'h11, 64'h55, 0, 100000, 0, 0, 0, '0, '0, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
